// File: rtl/vga_rect_layer_ctrl.sv
// Rectangle layer: 4 shadow/active descriptors, frame-synced commit,
// fixed-priority pixel colour with registered 1-bit R/G/B outputs.
module vga_rect_layer_ctrl #(
  parameter int NUM_RECT = 4,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic           in_clock,
  input  logic           in_reset,
  input  logic           in_strobe,
  input  logic [X_W-1:0] in_x,
  input  logic [Y_W-1:0] in_y,
  input  logic           in_active,
  input  logic           in_frame_end,
  input  logic           in_wr_valid,
  input  logic [1:0]     in_wr_idx,
  input  logic [2:0]     in_wr_field,
  input  logic [9:0]     in_wr_data,
  output logic           out_wr_ready,
  input  logic           in_commit,
  output logic           out_commit_pending,
  output logic           out_commit_done,
  output logic           out_red,
  output logic           out_green,
  output logic           out_blue
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   copy;

  logic [X_W-1:0] sh_x0 [NUM_RECT];
  logic [Y_W-1:0] sh_y0 [NUM_RECT];
  logic [X_W-1:0] sh_x1 [NUM_RECT];
  logic [Y_W-1:0] sh_y1 [NUM_RECT];
  logic [3:0]     sh_at [NUM_RECT];

  logic [X_W-1:0] ac_x0 [NUM_RECT];
  logic [Y_W-1:0] ac_y0 [NUM_RECT];
  logic [X_W-1:0] ac_x1 [NUM_RECT];
  logic [Y_W-1:0] ac_y1 [NUM_RECT];
  logic [3:0]     ac_at [NUM_RECT];

  logic [NUM_RECT-1:0] hit;
  logic [2:0]          pix_rgb;
  logic [2:0]          rgb_q;
  logic                done_q;
  logic                wr_en;

  assign out_wr_ready       = (state_q == IDLE);
  assign out_commit_pending = (state_q == PENDING);
  assign out_commit_done    = done_q;
  assign wr_en              = in_wr_valid & out_wr_ready;

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Commits only land while pending, so the copy edge never
  // coincides with a shadow write (ready is low then).
  always_comb begin
    state_d = state_q;
    copy    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_commit) state_d = PENDING;
      end
      PENDING: begin
        if (in_frame_end) begin
          copy    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        sh_x0[i] <= '0;
        sh_y0[i] <= '0;
        sh_x1[i] <= '0;
        sh_y1[i] <= '0;
        sh_at[i] <= '0;
      end
    end else if (wr_en) begin
      case (in_wr_field)
        3'd0: sh_x0[in_wr_idx] <= in_wr_data[X_W-1:0];
        3'd1: sh_y0[in_wr_idx] <= in_wr_data[Y_W-1:0];
        3'd2: sh_x1[in_wr_idx] <= in_wr_data[X_W-1:0];
        3'd3: sh_y1[in_wr_idx] <= in_wr_data[Y_W-1:0];
        3'd4: sh_at[in_wr_idx] <= in_wr_data[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        ac_x0[i] <= '0;
        ac_y0[i] <= '0;
        ac_x1[i] <= '0;
        ac_y1[i] <= '0;
        ac_at[i] <= '0;
      end
    end else if (copy) begin
      ac_x0 <= sh_x0;
      ac_y0 <= sh_y0;
      ac_x1 <= sh_x1;
      ac_y1 <= sh_y1;
      ac_at <= sh_at;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RECT; i++) begin
      hit[i] = ac_at[i][3]
             & (in_x > ac_x0[i]) & (in_x < ac_x1[i])
             & (in_y > ac_y0[i]) & (in_y < ac_y1[i]);
    end
  end

  // Walk from highest index down so the lowest hit wins.
  always_comb begin
    pix_rgb = 3'b000;
    for (int i = NUM_RECT - 1; i >= 0; i--) begin
      if (hit[i]) pix_rgb = ac_at[i][2:0];
    end
    if (!in_active) pix_rgb = 3'b000;
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      rgb_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= copy;
      if (in_strobe) rgb_q <= pix_rgb;
    end
  end

  assign out_red   = rgb_q[2];
  assign out_green = rgb_q[1];
  assign out_blue  = rgb_q[0];

endmodule

// File: tb/tb_vga_rect_layer_ctrl.sv
// Bench for vga_rect_layer_ctrl: directed test-plan sequences plus
// random traffic, all checked against a frame-level reference model.
module tb_vga_rect_layer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       strobe;
  logic [9:0] x;
  logic [8:0] y;
  logic       act;
  logic       fe;
  logic       wr_valid;
  logic [1:0] wr_idx;
  logic [2:0] wr_field;
  logic [9:0] wr_data;
  logic       wr_ready;
  logic       commit;
  logic       pending;
  logic       done;
  logic       r, g, b;

  always #10 clk = ~clk;

  vga_rect_layer_ctrl dut (
    .in_clock          (clk),
    .in_reset          (rst_n),
    .in_strobe         (strobe),
    .in_x              (x),
    .in_y              (y),
    .in_active         (act),
    .in_frame_end      (fe),
    .in_wr_valid       (wr_valid),
    .in_wr_idx         (wr_idx),
    .in_wr_field       (wr_field),
    .in_wr_data        (wr_data),
    .out_wr_ready      (wr_ready),
    .in_commit         (commit),
    .out_commit_pending(pending),
    .out_commit_done   (done),
    .out_red           (r),
    .out_green         (g),
    .out_blue          (b)
  );

  typedef struct {
    int x0, y0, x1, y1, en, rgb;
  } rect_t;

  rect_t sh[4];
  rect_t ac[4];
  int    pend_m, done_m, rgb_m;
  int    n_tests, n_fail;
  int    n_done;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pixel(int px, int py, int pa);
    if (pa == 0) return 0;
    for (int i = 0; i < 4; i++) begin
      if (ac[i].en != 0 && px > ac[i].x0 && px < ac[i].x1 &&
          py > ac[i].y0 && py < ac[i].y1)
        return ac[i].rgb;
    end
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      sh[i] = '{0, 0, 0, 0, 0, 0};
      ac[i] = '{0, 0, 0, 0, 0, 0};
    end
    pend_m = 0;
    done_m = 0;
    rgb_m  = 0;
  endtask

  task automatic check_outs(string tag);
    check({tag, ".ready"}, 32'(wr_ready), 32'(pend_m == 0));
    check({tag, ".pend"}, 32'(pending), 32'(pend_m));
    check({tag, ".done"}, 32'(done), 32'(done_m));
    check({tag, ".rgb"}, 32'({r, g, b}), 32'(rgb_m));
  endtask

  task automatic step(string tag);
    int nr;
    @(posedge clk);
    nr = rgb_m;
    if (strobe) nr = pixel(int'(x), int'(y), int'(act));
    if (pend_m == 0 && wr_valid && wr_field < 5) begin
      case (wr_field)
        3'd0: sh[wr_idx].x0 = int'(wr_data);
        3'd1: sh[wr_idx].y0 = int'(wr_data) % 512;
        3'd2: sh[wr_idx].x1 = int'(wr_data);
        3'd3: sh[wr_idx].y1 = int'(wr_data) % 512;
        default: begin
          sh[wr_idx].en  = int'(wr_data[3]);
          sh[wr_idx].rgb = int'(wr_data[2:0]);
        end
      endcase
    end
    done_m = 0;
    if (pend_m != 0 && fe) begin
      ac     = sh;
      pend_m = 0;
      done_m = 1;
    end else if (pend_m == 0 && commit) begin
      pend_m = 1;
    end
    rgb_m = nr;
    #1;
    if (done) n_done++;
    check_outs(tag);
  endtask

  task automatic idle_in();
    strobe   = 0;
    fe       = 0;
    wr_valid = 0;
    commit   = 0;
  endtask

  task automatic wr(int idx, int fld, int data);
    wr_valid = 1;
    wr_idx   = 2'(idx);
    wr_field = 3'(fld);
    wr_data  = 10'(data);
    step("wr");
    wr_valid = 0;
  endtask

  task automatic rect(int idx, int x0, int y0, int x1, int y1, int at);
    wr(idx, 0, x0);
    wr(idx, 1, y0);
    wr(idx, 2, x1);
    wr(idx, 3, y1);
    wr(idx, 4, at);
  endtask

  task automatic pix(int px, int py, int pa);
    strobe = 1;
    x      = 10'(px);
    y      = 9'(py);
    act    = pa[0];
    step("pix");
    strobe = 0;
  endtask

  task automatic do_commit();
    commit = 1;
    step("commit");
    commit = 0;
  endtask

  task automatic do_fe();
    fe = 1;
    step("fe");
    fe = 0;
  endtask

  task automatic do_reset();
    #4 rst_n = 0;
    #2;
    model_clear();
    check_outs("rst");
    @(negedge clk);
    rst_n = 1;
    #1 check("rst.ready_after", 32'(wr_ready), 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_done  = 0;
    rst_n   = 0;
    x       = 0;
    y       = 0;
    act     = 1;
    wr_idx  = 0;
    wr_field = 0;
    wr_data = 0;
    idle_in();
    model_clear();
    #25;
    check_outs("por");
    @(negedge clk);
    rst_n = 1;

    // a frame's worth of sparse pixels with nothing committed
    for (int i = 0; i < 40; i++) pix(i * 16, i * 12, 1);
    do_fe();
    check("blank.rgb", 32'({r, g, b}), 32'd0);

    // single green rectangle
    rect(0, 120, 40, 280, 200, 4'b1010);
    do_commit();
    n_done = 0;
    do_fe();
    step("post_fe");
    check("r0.done_once", 32'(n_done), 32'd1);
    pix(200, 100, 1);
    check("r0.green", 32'({r, g, b}), 32'b010);
    pix(120, 100, 1);
    check("r0.edge_black", 32'({r, g, b}), 32'd0);

    // overlapping red rectangle, rect0 has priority
    rect(1, 200, 120, 360, 280, 4'b1100);
    do_commit();
    do_fe();
    pix(250, 150, 1);
    check("ovl.green", 32'({r, g, b}), 32'b010);
    pix(300, 250, 1);
    check("ovl.red", 32'({r, g, b}), 32'b100);
    pix(250, 150, 0);
    check("ovl.inactive", 32'({r, g, b}), 32'd0);

    // write while pending is dropped
    do_commit();
    rect(2, 400, 300, 600, 450, 4'b1001);
    check("drop.ready", 32'(wr_ready), 32'd0);
    do_fe();
    pix(500, 400, 1);
    check("drop.black", 32'({r, g, b}), 32'd0);

    // commit together with frame_end defers the copy
    rect(3, 500, 350, 700, 500, 4'b1011);
    commit = 1;
    fe     = 1;
    n_done = 0;
    step("cfe");
    idle_in();
    step("cfe2");
    check("cfe.no_done", 32'(n_done), 32'd0);
    do_commit();
    pix(600, 400, 1);
    check("cfe.old", 32'({r, g, b}), 32'd0);
    do_fe();
    step("cfe3");
    check("cfe.done", 32'(n_done), 32'd1);
    pix(600, 400, 1);
    check("cfe.new", 32'({r, g, b}), 32'b011);

    // reset during pending discards the commit
    rect(0, 0, 0, 1023, 511, 4'b1111);
    do_commit();
    do_reset();
    n_done = 0;
    do_fe();
    step("rst_fe");
    check("rstp.no_done", 32'(n_done), 32'd0);
    pix(600, 400, 1);
    check("rstp.black", 32'({r, g, b}), 32'd0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      strobe   = ($urandom_range(0, 1) == 1);
      x        = 10'($urandom_range(0, 1023));
      y        = 9'($urandom_range(0, 511));
      act      = ($urandom_range(0, 7) != 0);
      fe       = ($urandom_range(0, 24) == 0);
      commit   = ($urandom_range(0, 9) == 0);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_idx   = 2'($urandom_range(0, 3));
      wr_field = 3'($urandom_range(0, 7));
      wr_data  = 10'($urandom_range(0, 1023));
      step("rnd");
      if ($urandom_range(0, 599) == 0) begin
        idle_in();
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
